niosii_system_sysid_checker: RTL and testbench

Avalon-MM master that reads the system-ID slave's ID word (address 0) and timestamp word (address 1) and compares both against build-time expected values. It sits between the sysid slave's control_slave port and a status/LED register. It runs automatically after reset or on a start pulse. Its pass/fail flags tell hardware and Nios II software that the loaded FPGA image matches the software build.

---
 rtl/niosii_system_sysid_pkg.sv | 26 ++
 rtl/niosii_system_sysid_timeout_ctr.sv | 51 +++++
 rtl/niosii_system_sysid_checker.sv | 175 +++++++++++++++++
 tb/tb_niosii_system_sysid_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/niosii_system_sysid_pkg.sv
// ============================================================================
// Module : niosII_system_sysid_pkg
// Brief  : Shared state encoding, sysid word addresses and expected values
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package niosII_system_sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_EVAL  = 2'd3
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID = 32'd0;
    localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1392140734;

endpackage

`default_nettype wire

// File: rtl/niosii_system_sysid_timeout_ctr.sv
// ============================================================================
// Module : niosII_system_sysid_timeout_ctr
// Brief  : Loadable saturating wait counter with clear, enable and expiry flag
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module niosII_system_sysid_timeout_ctr #(
    parameter int unsigned W     = 8,
    parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    localparam logic [W-1:0] c_LAST = LIMIT - W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the enabled cycle that brings the count up to LIMIT.
    assign expired_o = en_i && (count_q >= c_LAST);

endmodule

`default_nettype wire

// File: rtl/niosii_system_sysid_checker.sv
// ============================================================================
// Module : niosii_system_sysid_checker
// Brief  : Avalon-MM master that reads sysid ID/timestamp and flags mismatches
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module niosii_system_sysid_checker
    import niosII_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts
);

    sysid_state_e state_q, state_d;
    logic         avm_read_q, avm_read_d;
    logic         avm_address_q, avm_address_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         id_mm_q, id_mm_d;
    logic         ts_mm_q, ts_mm_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  read_id_q, read_id_d;
    logic [31:0]  read_ts_q, read_ts_d;
    logic         auto_pending_q, auto_pending_d;

    logic         w_ctr_clr;
    logic         w_ctr_en;
    logic         w_ctr_expired;

    niosII_system_sysid_timeout_ctr #(
        .W     (TO_W),
        .LIMIT (TO_W'(TIMEOUT_CYCLES))
    ) u_timeout_ctr (
        .clk        (clock),
        .rst_n      (reset_n),
        .clr_i      (w_ctr_clr),
        .en_i       (w_ctr_en),
        .load_i     (1'b0),
        .load_val_i ({TO_W{1'b0}}),
        .expired_o  (w_ctr_expired)
    );

    always_comb begin
        state_d        = state_q;
        avm_read_d     = avm_read_q;
        avm_address_d  = avm_address_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        id_mm_d        = id_mm_q;
        ts_mm_d        = ts_mm_q;
        timeout_d      = timeout_q;
        read_id_d      = read_id_q;
        read_ts_d      = read_ts_q;
        auto_pending_d = auto_pending_q;
        w_ctr_clr      = 1'b0;
        w_ctr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_pending_q) begin
                    state_d        = ST_RD_ID;
                    pass_d         = 1'b0;
                    id_mm_d        = 1'b0;
                    ts_mm_d        = 1'b0;
                    timeout_d      = 1'b0;
                    auto_pending_d = 1'b0;
                    w_ctr_clr      = 1'b1;
                    busy_d         = 1'b1;
                    avm_read_d     = 1'b1;
                    avm_address_d  = SYSID_ADDR_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                // Read/address registers hold their value while stalled.
                w_ctr_en = avm_waitrequest;
                if (!avm_waitrequest) begin
                    w_ctr_clr = 1'b1;
                    if (state_q == ST_RD_ID) begin
                        read_id_d     = avm_readdata;
                        avm_address_d = SYSID_ADDR_TS;
                        state_d       = ST_RD_TS;
                    end else begin
                        read_ts_d  = avm_readdata;
                        avm_read_d = 1'b0;
                        state_d    = ST_EVAL;
                    end
                end else if (w_ctr_expired) begin
                    avm_read_d = 1'b0;
                    timeout_d  = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_EVAL: begin
                id_mm_d = (read_id_q != EXPECTED_ID);
                ts_mm_d = (read_ts_q != EXPECTED_TS);
                pass_d  = (read_id_q == EXPECTED_ID) && (read_ts_q == EXPECTED_TS);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            avm_read_q     <= 1'b0;
            avm_address_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            id_mm_q        <= 1'b0;
            ts_mm_q        <= 1'b0;
            timeout_q      <= 1'b0;
            read_id_q      <= 32'd0;
            read_ts_q      <= 32'd0;
            auto_pending_q <= AUTO_START;
        end else begin
            state_q        <= state_d;
            avm_read_q     <= avm_read_d;
            avm_address_q  <= avm_address_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            id_mm_q        <= id_mm_d;
            ts_mm_q        <= ts_mm_d;
            timeout_q      <= timeout_d;
            read_id_q      <= read_id_d;
            read_ts_q      <= read_ts_d;
            auto_pending_q <= auto_pending_d;
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout     = timeout_q;
    assign read_id     = read_id_q;
    assign read_ts     = read_ts_q;

endmodule

`default_nettype wire

// File: tb/tb_niosii_system_sysid_checker.sv
// ============================================================================
// Module : tb_niosii_system_sysid_checker
// Brief  : Directed bench; dut_a auto-starts (timeout 255), dut_b manual (timeout 4)
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_niosii_system_sysid_checker;

    localparam logic [31:0] c_TS = 32'd1392140734;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        a_start = 1'b0, b_start = 1'b0;
    logic        a_addr, a_read, a_wait, a_busy, a_done, a_pass, a_idmm, a_tsmm, a_to;
    logic        b_addr, b_read, b_wait, b_busy, b_done, b_pass, b_idmm, b_tsmm, b_to;
    logic [31:0] a_rdata, a_rid, a_rts, b_rdata, b_rid, b_rts;

    // Slave models: data per word, programmable stall count per read.
    logic [31:0] a_id = 32'd0, a_ts = c_TS, b_id = 32'd0, b_ts = c_TS;
    int a_stall = 0, b_stall = 0, a_scnt = 0, b_scnt = 0;

    assign a_rdata = a_addr ? a_ts : a_id;
    assign b_rdata = b_addr ? b_ts : b_id;
    assign a_wait  = a_read && (a_scnt < a_stall);
    assign b_wait  = b_read && (b_scnt < b_stall);

    niosii_system_sysid_checker dut_a (
        .clock(clk), .reset_n(rst_n), .start(a_start),
        .avm_address(a_addr), .avm_read(a_read), .avm_readdata(a_rdata),
        .avm_waitrequest(a_wait), .busy(a_busy), .done(a_done), .pass(a_pass),
        .id_mismatch(a_idmm), .ts_mismatch(a_tsmm), .timeout(a_to),
        .read_id(a_rid), .read_ts(a_rts)
    );

    niosii_system_sysid_checker #(.AUTO_START(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
        .clock(clk), .reset_n(rst_n), .start(b_start),
        .avm_address(b_addr), .avm_read(b_read), .avm_readdata(b_rdata),
        .avm_waitrequest(b_wait), .busy(b_busy), .done(b_done), .pass(b_pass),
        .id_mismatch(b_idmm), .ts_mismatch(b_tsmm), .timeout(b_to),
        .read_id(b_rid), .read_ts(b_rts)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_scnt <= 0;
            b_scnt <= 0;
        end else begin
            a_scnt <= (a_read && a_wait) ? a_scnt + 1 : 0;
            b_scnt <= (b_read && b_wait) ? b_scnt + 1 : 0;
        end
    end

    // Bus monitors: address/read stability on dut_a, activity counters on dut_b.
    logic a_prev_stall = 1'b0, a_prev_addr = 1'b0;
    int   a_viol = 0, a_stall_seen = 0, b_rd_cyc = 0, b_ts_cyc = 0, b_done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_prev_stall && (!a_read || a_addr !== a_prev_addr)) a_viol <= a_viol + 1;
            a_prev_stall <= a_read && a_wait;
            a_prev_addr  <= a_addr;
            if (a_read && a_wait) a_stall_seen <= a_stall_seen + 1;
            if (b_read)           b_rd_cyc     <= b_rd_cyc + 1;
            if (b_read && b_addr) b_ts_cyc     <= b_ts_cyc + 1;
            if (b_done)           b_done_cnt   <= b_done_cnt + 1;
        end else begin
            a_prev_stall <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        int          stall;
        int          lat;
        logic        pass;
        logic        idmm;
        logic        tsmm;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, d0, r0, t0;

        vecs[0] = '{32'h0000_0000, c_TS,               0, 4,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0001, c_TS,               0, 4,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000,      0, 4,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, c_TS ^ 32'h1,       0, 4,  1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0000, c_TS,               3, 10, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, c_TS,               1, 6,  1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_ctl", {a_read, a_addr, a_busy, a_done, a_pass, a_idmm, a_tsmm, a_to}, 8'h00);
        check("rst_a_data", {a_rid, a_rts}, 64'd0);
        check("rst_b_ctl", {b_read, b_addr, b_busy, b_done, b_pass, b_idmm, b_tsmm, b_to}, 8'h00);

        // Auto-start check after reset release
        rst_n = 1'b1;
        @(negedge clk); check("auto_rd_id {read,addr,busy}", {a_read, a_addr, a_busy}, 3'b101);
        @(negedge clk); check("auto_rd_ts {read,addr,busy}", {a_read, a_addr, a_busy}, 3'b111);
        @(negedge clk); check("auto_eval {read,busy,done}", {a_read, a_busy, a_done}, 3'b010);
        @(negedge clk);
        check("auto_done {done,busy,pass,idmm,tsmm,to}",
              {a_done, a_busy, a_pass, a_idmm, a_tsmm, a_to}, 6'b101000);
        check("auto_read_id", a_rid, 32'd0);
        check("auto_read_ts", a_rts, 32'd1392140734);
        @(negedge clk); check("auto_done_pulse {done,pass}", {a_done, a_pass}, 2'b01);
        check("b_stays_idle {busy,read,done}", {b_busy, b_read, b_done}, 3'b000);

        // Table-driven checks on dut_a via start pulses
        foreach (vecs[i]) begin
            a_id = vecs[i].id; a_ts = vecs[i].ts; a_stall = vecs[i].stall;
            @(negedge clk); a_start = 1'b1;
            @(negedge clk); a_start = 1'b0; cyc = 1;
            check($sformatf("v%0d_entry {busy,pass,idmm,tsmm,to}", i),
                  {a_busy, a_pass, a_idmm, a_tsmm, a_to}, 5'b10000);
            while (!a_done && cyc < 200) begin @(negedge clk); cyc++; end
            check($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
            check($sformatf("v%0d_flags {pass,idmm,tsmm,to,busy}", i),
                  {a_pass, a_idmm, a_tsmm, a_to, a_busy},
                  {vecs[i].pass, vecs[i].idmm, vecs[i].tsmm, 1'b0, 1'b0});
            check($sformatf("v%0d_read_id", i), a_rid, vecs[i].id);
            check($sformatf("v%0d_read_ts", i), a_rts, vecs[i].ts);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_sticky {done,pass}", i), {a_done, a_pass}, {1'b0, vecs[i].pass});
        end
        check("stall_cycles_seen", a_stall_seen, 8);
        check("addr_stable_violations", a_viol, 0);

        // Timeout on dut_b: slave stalls forever, limit of 4 wait cycles
        b_stall = 1000; t0 = b_ts_cyc; d0 = b_done_cnt;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; cyc = 1;
        while (!b_done && cyc < 200) begin @(negedge clk); cyc++; end
        check("to_latency", cyc, 5);
        check("to_flags {read,busy,pass,idmm,tsmm,to}",
              {b_read, b_busy, b_pass, b_idmm, b_tsmm, b_to}, 6'b000001);
        @(negedge clk);
        check("to_done_once", b_done_cnt - d0, 1);
        check("to_no_ts_access", b_ts_cyc - t0, 0);

        // Start pulse while busy is dropped
        b_stall = 3; b_id = 32'd0; b_ts = c_TS; d0 = b_done_cnt;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; cyc = 1;
        while (!b_done && cyc < 200) begin
            @(negedge clk); cyc++;
            b_start = (cyc == 2);
        end
        b_start = 1'b0;
        check("ign_latency", cyc, 10);
        check("ign_flags {pass,to}", {b_pass, b_to}, 2'b10);
        r0 = b_rd_cyc;
        repeat (6) @(negedge clk);
        check("ign_no_rerun_reads", b_rd_cyc - r0, 0);
        check("ign_done_once", b_done_cnt - d0, 1);

        // Asynchronous reset in the middle of a timestamp read on dut_b
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; cyc = 0;
        while (!(b_read && b_addr) && cyc < 50) begin @(negedge clk); cyc++; end
        check("mid_ts_reached", {b_read, b_addr}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_b_ctl", {b_read, b_addr, b_busy, b_done, b_pass, b_idmm, b_tsmm, b_to}, 8'h00);
        check("async_rst_b_data", {b_rid, b_rts}, 64'd0);
        check("async_rst_a_ctl", {a_read, a_busy, a_done, a_pass}, 4'h0);
        a_id = 32'd0; a_ts = c_TS; a_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; r0 = b_rd_cyc; cyc = 0;
        do begin @(negedge clk); cyc++; end while (!a_done && cyc < 200);
        check("rerun_a_latency", cyc, 4);
        check("rerun_a_pass", a_pass, 1'b1);
        repeat (3) @(negedge clk);
        check("b_idle_after_rst {busy,reads}", {b_busy, 32'(b_rd_cyc - r0)}, 33'd0);

        // dut_b runs again only on an explicit start
        b_stall = 0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; cyc = 1;
        while (!b_done && cyc < 200) begin @(negedge clk); cyc++; end
        check("b_restart_latency", cyc, 4);
        check("b_restart_pass", {b_pass, b_idmm, b_tsmm, b_to}, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
